slice_component_scheduler: RTL and testbench

Sequences one component datapath instance through the three passes of a slice: Y, then Cb, then Cr.
For each pass it drives the datapath's reset, component select, block count and input-memory offset.
It monitors the datapath's bitstream-writer outputs to detect end of component, and accumulates per-component coded sizes in bytes for the slice header.
It sits between the slice-level controller and the component datapath, and owns the datapath's reset_n.

---
 rtl/slice_component_scheduler_pkg.sv | 33 +++
 rtl/slice_component_scheduler_comp_size_accum.sv | 36 +++
 rtl/slice_component_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_slice_component_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_component_scheduler_pkg.sv
// Shared types for the slice component scheduler: FSM states, component select, strobe limits.
// Pure declarations; no timing or flow control of its own.
package prores_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_Y,
    RUN_Y,
    RST_CB,
    RUN_CB,
    RST_CR,
    RUN_CR,
    DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    COMP_Y,
    COMP_CB,
    COMP_CR
  } comp_sel_t;

  localparam int MAX_SB_BITS = 64;
  localparam int SB_BITS_W   = $clog2(MAX_SB_BITS + 1);

  function automatic comp_sel_t state_comp(input sched_state_t s);
    case (s)
      RST_CB, RUN_CB: return COMP_CB;
      RST_CR, RUN_CR: return COMP_CR;
      default:        return COMP_Y;
    endcase
  endfunction

endpackage

// File: rtl/slice_component_scheduler_comp_size_accum.sv
// Per-pass bit accumulator; bytes_sat is ceil(bits/8) including this cycle's add, saturated to SIZE_W.
// One-cycle state update, no backpressure; clear wins over the stored value but not over the reported sum.
module comp_size_accum
  import prores_enc_pkg::*;
#(
  parameter int SIZE_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 add_en,
  input  logic [SB_BITS_W-1:0] add_bits,
  output logic [SIZE_W-1:0]    bytes_sat
);

  localparam logic [29:0] MAX_BYTES = 30'((64'd1 << SIZE_W) - 64'd1);

  logic [31:0] acc_q, acc_d;
  logic [31:0] sum;
  logic [32:0] sum_round;
  logic [29:0] bytes;

  always_comb begin
    sum       = acc_q + (add_en ? 32'(add_bits) : 32'd0);
    sum_round = {1'b0, sum} + 33'd7;
    bytes     = sum_round[32:3];
    bytes_sat = (bytes > MAX_BYTES) ? MAX_BYTES[SIZE_W-1:0] : bytes[SIZE_W-1:0];
    acc_d     = clear ? 32'd0 : sum;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/slice_component_scheduler.sv
// Runs one component datapath through Y, Cb, Cr passes, owning its reset and tallying coded bytes.
// RUN starts RESET_HOLD cycles after entering RST; start is ignored outside IDLE, no other backpressure.
module slice_component_scheduler
  import prores_enc_pkg::*;
#(
  parameter int RESET_HOLD = 2,
  parameter int TIMEOUT    = 65535,
  parameter int SIZE_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       luma_block_num,
  input  logic [31:0]       chroma_block_num,
  input  logic [31:0]       y_offset,
  input  logic [31:0]       cb_offset,
  input  logic [31:0]       cr_offset,
  input  logic              sb_enable,
  input  logic [63:0]       sb_size_of_bit,
  input  logic              sb_flush,
  output logic              component_reset_n,
  output logic              comp_is_y,
  output logic [31:0]       comp_block_num,
  output logic [31:0]       comp_offset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [SIZE_W-1:0] y_size,
  output logic [SIZE_W-1:0] cb_size,
  output logic [SIZE_W-1:0] cr_size
);

  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

  sched_state_t      state_q, state_d;
  logic [31:0]       hold_cnt_q, hold_cnt_d, run_cnt_q, run_cnt_d;
  logic              error_q, error_d;
  logic [SIZE_W-1:0] y_size_q, y_size_d, cb_size_q, cb_size_d, cr_size_q, cr_size_d;
  logic [31:0]       luma_q, luma_d, chroma_q, chroma_d;
  logic [31:0]       y_off_q, y_off_d, cb_off_q, cb_off_d, cr_off_q, cr_off_d;

  logic              run_active, complete, timeout, acc_clear;
  logic [SIZE_W-1:0] pass_bytes;
  logic              unused_sb_hi;

  // Only the low bits of the strobe size are meaningful; anything above 64 is out of contract.
  assign unused_sb_hi = ^sb_size_of_bit[63:SB_BITS_W];

  assign run_active = (state_q == RUN_Y) || (state_q == RUN_CB) || (state_q == RUN_CR);
  assign complete   = run_active && sb_enable && sb_flush;
  assign timeout    = run_active && !complete && (run_cnt_q == TO_LAST);

  comp_size_accum #(.SIZE_W(SIZE_W)) u_accum (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (acc_clear),
    .add_en    (run_active && sb_enable),
    .add_bits  (sb_size_of_bit[SB_BITS_W-1:0]),
    .bytes_sat (pass_bytes)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    run_cnt_d  = run_cnt_q;
    error_d    = error_q;
    y_size_d   = y_size_q;
    cb_size_d  = cb_size_q;
    cr_size_d  = cr_size_q;
    luma_d     = luma_q;
    chroma_d   = chroma_q;
    y_off_d    = y_off_q;
    cb_off_d   = cb_off_q;
    cr_off_d   = cr_off_q;
    acc_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RST_Y;
          hold_cnt_d = '0;
          error_d    = 1'b0;
          y_size_d   = '0;
          cb_size_d  = '0;
          cr_size_d  = '0;
          acc_clear  = 1'b1;
          luma_d     = luma_block_num;
          chroma_d   = chroma_block_num;
          y_off_d    = y_offset;
          cb_off_d   = cb_offset;
          cr_off_d   = cr_offset;
        end
      end
      RST_Y, RST_CB, RST_CR: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          run_cnt_d  = '0;
          case (state_q)
            RST_Y:   state_d = RUN_Y;
            RST_CB:  state_d = RUN_CB;
            default: state_d = RUN_CR;
          endcase
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      RUN_Y, RUN_CB, RUN_CR: begin
        run_cnt_d = run_cnt_q + 32'd1;
        if (complete || timeout) begin
          acc_clear = 1'b1;
          case (state_comp(state_q))
            COMP_Y:  y_size_d  = pass_bytes;
            COMP_CB: cb_size_d = pass_bytes;
            default: cr_size_d = pass_bytes;
          endcase
          // A timed-out pass abandons the rest of the slice.
          if (timeout) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            case (state_q)
              RUN_Y:   state_d = RST_CB;
              RUN_CB:  state_d = RST_CR;
              default: state_d = DONE;
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      run_cnt_q  <= '0;
      error_q    <= 1'b0;
      y_size_q   <= '0;
      cb_size_q  <= '0;
      cr_size_q  <= '0;
      luma_q     <= '0;
      chroma_q   <= '0;
      y_off_q    <= '0;
      cb_off_q   <= '0;
      cr_off_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      run_cnt_q  <= run_cnt_d;
      error_q    <= error_d;
      y_size_q   <= y_size_d;
      cb_size_q  <= cb_size_d;
      cr_size_q  <= cr_size_d;
      luma_q     <= luma_d;
      chroma_q   <= chroma_d;
      y_off_q    <= y_off_d;
      cb_off_q   <= cb_off_d;
      cr_off_q   <= cr_off_d;
    end
  end

  always_comb begin
    comp_block_num = '0;
    comp_offset    = '0;
    case (state_q)
      RST_Y, RUN_Y: begin
        comp_block_num = luma_q;
        comp_offset    = y_off_q;
      end
      RST_CB, RUN_CB: begin
        comp_block_num = chroma_q;
        comp_offset    = cb_off_q;
      end
      RST_CR, RUN_CR: begin
        comp_block_num = chroma_q;
        comp_offset    = cr_off_q;
      end
      default: ;
    endcase
  end

  assign component_reset_n = run_active;
  assign comp_is_y         = (state_q == RST_Y) || (state_q == RUN_Y);
  assign busy              = (state_q != IDLE) && (state_q != DONE);
  assign done              = (state_q == DONE);
  assign error             = error_q;
  assign y_size            = y_size_q;
  assign cb_size           = cb_size_q;
  assign cr_size           = cr_size_q;

endmodule

// File: tb/tb_slice_component_scheduler.sv
// Bench for slice_component_scheduler: table rows for the named corner cases plus random slices vs a pass model.
module tb_slice_component_scheduler;

  localparam int RH = 2;
  localparam int TO = 100;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset_n, start, sb_enable, sb_flush;
  logic [31:0]   luma_block_num, chroma_block_num, y_offset, cb_offset, cr_offset;
  logic [63:0]   sb_size_of_bit;
  logic          component_reset_n, comp_is_y, busy, done, error;
  logic [31:0]   comp_block_num, comp_offset;
  logic [SW-1:0] y_size, cb_size, cr_size;

  slice_component_scheduler #(.RESET_HOLD(RH), .TIMEOUT(TO), .SIZE_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .luma_block_num(luma_block_num), .chroma_block_num(chroma_block_num),
    .y_offset(y_offset), .cb_offset(cb_offset), .cr_offset(cr_offset),
    .sb_enable(sb_enable), .sb_size_of_bit(sb_size_of_bit), .sb_flush(sb_flush),
    .component_reset_n(component_reset_n), .comp_is_y(comp_is_y),
    .comp_block_num(comp_block_num), .comp_offset(comp_offset),
    .busy(busy), .done(done), .error(error),
    .y_size(y_size), .cb_size(cb_size), .cr_size(cr_size)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(posedge clock) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  typedef struct packed { logic en; logic fl; logic [6:0] bits; } cyc_t;
  typedef cyc_t cyc_q_t[$];
  typedef struct packed { logic [3:0] n; logic [6:0] bits; logic [6:0] last; logic flush; logic spur; } pass_t;
  typedef struct packed {
    pass_t y, cb, cr;
    logic [4:0] ey, ecb, ecr;
    logic eerr, start_mid, abort;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pass_t mkp(input int n, input int b, input int l, input bit fl, input bit sp);
    pass_t p;
    p.n = 4'(n); p.bits = 7'(b); p.last = 7'(l); p.flush = fl; p.spur = sp;
    return p;
  endfunction

  function automatic vec_t mkv(input pass_t y, input pass_t cb, input pass_t cr,
                               input int ey, input int ecb, input int ecr,
                               input bit eerr, input bit sm, input bit ab);
    vec_t v;
    v.y = y; v.cb = cb; v.cr = cr;
    v.ey = 5'(ey); v.ecb = 5'(ecb); v.ecr = 5'(ecr);
    v.eerr = eerr; v.start_mid = sm; v.abort = ab;
    return v;
  endfunction

  // n plain strobes, optionally a flush-without-enable cycle after the first, then the flush strobe.
  function automatic cyc_q_t expand(input pass_t ps);
    cyc_q_t q;
    for (int i = 0; i < int'(ps.n); i++) begin
      q.push_back('{en: 1'b1, fl: 1'b0, bits: ps.bits});
      if (ps.spur && i == 0) q.push_back('{en: 1'b0, fl: 1'b1, bits: 7'd64});
    end
    if (ps.flush) q.push_back('{en: 1'b1, fl: 1'b1, bits: ps.last});
    return q;
  endfunction

  function automatic cyc_q_t rnd_pass();
    cyc_q_t q;
    int len = $urandom_range(1, 12);
    for (int i = 0; i < len - 1; i++)
      q.push_back('{en: 1'($urandom_range(0, 1)), fl: 1'($urandom_range(0, 3) == 0),
                    bits: 7'($urandom_range(0, 64))});
    q.push_back('{en: 1'b1, fl: 1'($urandom_range(0, 7) != 0), bits: 7'($urandom_range(0, 64))});
    return q;
  endfunction

  // Pass reference: enabled bits summed up to and including the first enable+flush,
  // limited to TO run cycles; bytes rounded up and clipped to the size field.
  function automatic void model_pass(input cyc_q_t q, output int bytes, output int ncyc, output bit ok);
    int sum = 0;
    ok = 1'b0;
    ncyc = TO;
    for (int i = 0; i < TO; i++) begin
      if (i < q.size()) begin
        if (q[i].en) sum += int'(q[i].bits);
        if (q[i].en && q[i].fl) begin
          ok = 1'b1;
          ncyc = i + 1;
          break;
        end
      end
    end
    bytes = (sum + 7) / 8;
    if (bytes > (1 << SW) - 1) bytes = (1 << SW) - 1;
  endfunction

  task automatic idle_inputs();
    sb_enable = 1'b0; sb_flush = 1'b0; sb_size_of_bit = '0; start = 1'b0;
  endtask

  task automatic run_slice(input cyc_q_t q0, input cyc_q_t q1, input cyc_q_t q2,
                           input logic [31:0] lb, input logic [31:0] cbn,
                           input logic [31:0] yo, input logic [31:0] cbo, input logic [31:0] cro,
                           input bit start_mid, input bit abort,
                           input int ey, input int ecb, input int ecr, input bit eerr);
    cyc_q_t q;
    int bytes, ncyc, lowc, i, d0;
    bit ok;
    logic [31:0] eblk, eoff;
    d0 = done_cnt;
    luma_block_num = lb; chroma_block_num = cbn;
    y_offset = yo; cb_offset = cbo; cr_offset = cro;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_crn", component_reset_n, 0);
    chk("start_err_clr", error, 0);
    chk("start_sizes_clr", {y_size, cb_size, cr_size}, 0);
    for (int p = 0; p < 3; p++) begin
      if (p == 0) q = q0; else if (p == 1) q = q1; else q = q2;
      eblk = (p == 0) ? lb : cbn;
      eoff = (p == 0) ? yo : ((p == 1) ? cbo : cro);
      model_pass(q, bytes, ncyc, ok);
      lowc = 0;
      while (!component_reset_n && lowc < 10) begin
        if (lowc == 0) begin
          chk("rst_is_y", comp_is_y, (p == 0));
          chk("rst_blk", comp_block_num, eblk);
          chk("rst_off", comp_offset, eoff);
        end
        lowc++;
        @(negedge clock);
      end
      chk("rst_hold", lowc, RH);
      i = 0;
      while (component_reset_n && i < TO + 5) begin
        if (i == 0) chk("run_is_y", comp_is_y, (p == 0));
        if (abort && p == 2 && i == 1) begin
          idle_inputs();
          reset_n = 1'b0;
          @(negedge clock);
          chk("abort_state", {component_reset_n, comp_is_y, busy, done, error}, 0);
          chk("abort_cfg", {comp_block_num, comp_offset}, 0);
          chk("abort_sizes", {y_size, cb_size, cr_size}, 0);
          reset_n = 1'b1;
          repeat (5) @(negedge clock);
          chk("abort_no_done", done_cnt - d0, 0);
          chk("abort_idle", busy, 0);
          return;
        end
        start = start_mid && p == 1 && i == 1;
        if (i < q.size()) begin
          sb_enable = q[i].en; sb_flush = q[i].fl; sb_size_of_bit = {57'd0, q[i].bits};
        end else begin
          sb_enable = 1'b0; sb_flush = 1'b0; sb_size_of_bit = '0;
        end
        @(negedge clock);
        i++;
      end
      idle_inputs();
      chk("run_len", i, ncyc);
      if (!ok) break;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_crn", component_reset_n, 0);
    chk("error", error, eerr);
    chk("y_size", y_size, ey);
    chk("cb_size", cb_size, ecb);
    chk("cr_size", cr_size, ecr);
    @(negedge clock);
    chk("after_done", {done, busy}, 0);
    chk("error_sticky", error, eerr);
    chk("done_count", done_cnt - d0, 1);
  endtask

  vec_t vecs [7];

  initial begin
    int ey, ecb, ecr, b, n;
    bit eerr, ok;
    cyc_q_t qa, qb, qc;

    vecs[0] = mkv(mkp(3, 20, 5, 1, 0), mkp(1, 10, 0, 1, 0), mkp(0, 0, 16, 1, 0), 9, 2, 2, 0, 0, 0);
    vecs[1] = mkv(mkp(3, 20, 5, 1, 0), mkp(1, 10, 0, 1, 0), mkp(0, 0, 16, 1, 0), 9, 2, 2, 0, 1, 0);
    vecs[2] = mkv(mkp(3, 64, 0, 1, 0), mkp(0, 0, 64, 1, 0), mkp(2, 7, 1, 1, 0), 15, 8, 2, 0, 0, 0);
    vecs[3] = mkv(mkp(1, 8, 8, 1, 1), mkp(0, 0, 8, 1, 0), mkp(0, 0, 0, 1, 0), 2, 1, 0, 0, 0, 0);
    vecs[4] = mkv(mkp(1, 12, 0, 0, 0), mkp(0, 0, 8, 1, 0), mkp(0, 0, 8, 1, 0), 2, 0, 0, 1, 0, 0);
    vecs[5] = mkv(mkp(3, 20, 5, 1, 0), mkp(1, 10, 0, 1, 0), mkp(0, 0, 16, 1, 0), 9, 2, 2, 0, 0, 0);
    vecs[6] = mkv(mkp(1, 10, 0, 1, 0), mkp(1, 10, 0, 1, 0), mkp(3, 10, 1, 1, 0), 0, 0, 0, 0, 0, 1);

    reset_n = 1'b0;
    idle_inputs();
    luma_block_num = '0; chroma_block_num = '0;
    y_offset = '0; cb_offset = '0; cr_offset = '0;
    repeat (3) @(negedge clock);
    chk("rst_crn", component_reset_n, 0);
    chk("rst_comp_is_y", comp_is_y, 0);
    chk("rst_blk_num", comp_block_num, 0);
    chk("rst_offset", comp_offset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_sizes", {y_size, cb_size, cr_size}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_after_rst", {busy, component_reset_n}, 0);

    for (int r = 0; r < 7; r++) begin
      run_slice(expand(vecs[r].y), expand(vecs[r].cb), expand(vecs[r].cr),
                32'd8, 32'd4, 32'd0, 32'd512, 32'd768,
                vecs[r].start_mid, vecs[r].abort,
                int'(vecs[r].ey), int'(vecs[r].ecb), int'(vecs[r].ecr), vecs[r].eerr);
      repeat (2) @(negedge clock);
    end

    for (int r = 0; r < 12; r++) begin
      qa = rnd_pass(); qb = rnd_pass(); qc = rnd_pass();
      ey = 0; ecb = 0; ecr = 0; eerr = 1'b0;
      model_pass(qa, b, n, ok);
      ey = b;
      if (!ok) eerr = 1'b1;
      else begin
        model_pass(qb, b, n, ok);
        ecb = b;
        if (!ok) eerr = 1'b1;
        else begin
          model_pass(qc, b, n, ok);
          ecr = b;
          if (!ok) eerr = 1'b1;
        end
      end
      run_slice(qa, qb, qc, $urandom, $urandom, $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'b0, ey, ecb, ecr, eerr);
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
